// File: rtl/video_box_downscaler_if.sv
// AXI4-Stream pixel channel used on both sides of the box downscaler.
// master drives data/valid/markers, slave drives ready.
interface video_box_downscaler_if #(
    parameter int PW = 24
);
    logic [PW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/video_box_downscaler.sv
// Box-filter (averaging) video downscaler.
// Decimates an AXI4-Stream frame by 2^h horizontally and 2^v vertically.
// Horizontal groups are summed on the fly. Partial column sums for the
// current vertical group live in a line accumulator. The rounded average
// is loaded into the output register on the beat that completes a block.
module video_box_downscaler #(
    parameter int CHANNELS       = 3,
    parameter int CHANNEL_WIDTH  = 8,
    parameter int MAX_SRC_WIDTH  = 3840,
    parameter int MAX_RATIO_LOG2 = 2,
    parameter int DIM_WIDTH      = 16
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DIM_WIDTH-1:0]   src_width,
    input  logic [DIM_WIDTH-1:0]   src_height,
    input  logic [1:0]             hratio_log2,
    input  logic [1:0]             vratio_log2,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   tlast_err,
    video_box_downscaler_if.slave  s_axis,
    video_box_downscaler_if.master m_axis
);
    localparam int PW    = CHANNELS * CHANNEL_WIDTH;
    localparam int HS_W  = CHANNEL_WIDTH + MAX_RATIO_LOG2;
    localparam int ACC_W = CHANNEL_WIDTH + 2 * MAX_RATIO_LOG2;
    localparam int LA_W  = CHANNELS * ACC_W;
    localparam int AW    = $clog2(MAX_SRC_WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    // True when a start request with this configuration must be refused.
    function automatic logic cfg_bad(input logic [DIM_WIDTH-1:0] w,
                                     input logic [DIM_WIDTH-1:0] hgt,
                                     input logic [1:0]           hl,
                                     input logic [1:0]           vl);
        logic [DIM_WIDTH-1:0] hm;
        logic [DIM_WIDTH-1:0] vm;
        hm = (DIM_WIDTH'(1) << hl) - DIM_WIDTH'(1);
        vm = (DIM_WIDTH'(1) << vl) - DIM_WIDTH'(1);
        return (w == '0) || (hgt == '0) || (w > DIM_WIDTH'(MAX_SRC_WIDTH)) ||
               (int'(hl) > MAX_RATIO_LOG2) || (int'(vl) > MAX_RATIO_LOG2) ||
               ((w & hm) != '0) || ((hgt & vm) != '0);
    endfunction

    // Block average: (total + 2^(sh-1)) >> sh, round half up; sh==0 passes through.
    function automatic logic [CHANNEL_WIDTH-1:0] round_half_up(input logic [ACC_W-1:0] total,
                                                               input logic [2:0]       sh);
        logic [ACC_W-1:0] half;
        logic [ACC_W-1:0] r;
        if (sh == 3'd0) begin
            r = total;
        end else begin
            half = ACC_W'(1) << (sh - 3'd1);
            r    = (total + half) >> sh;
        end
        return CHANNEL_WIDTH'(r);
    endfunction

    state_t                     state_q, state_d;
    logic [DIM_WIDTH-1:0]       cfg_w_q, cfg_w_d;
    logic [DIM_WIDTH-1:0]       cfg_h_q, cfg_h_d;
    logic [1:0]                 hl_q, hl_d;
    logic [1:0]                 vl_q, vl_d;
    logic [DIM_WIDTH-1:0]       in_x_q, in_x_d;
    logic [DIM_WIDTH-1:0]       in_y_q, in_y_d;
    logic                       in_done_q, in_done_d;
    logic [CHANNELS*HS_W-1:0]   hsum_q, hsum_d;
    logic                       first_out_q, first_out_d;
    logic                       final_out_q, final_out_d;
    logic [PW-1:0]              m_data_q, m_data_d;
    logic                       m_valid_q, m_valid_d;
    logic                       m_last_q, m_last_d;
    logic                       m_user_q, m_user_d;
    logic                       done_q, done_d;
    logic                       cfg_err_q, cfg_err_d;
    logic                       tlast_err_q, tlast_err_d;

    logic [LA_W-1:0]            line_mem [MAX_SRC_WIDTH];
    logic [AW-1:0]              mem_addr;
    logic [LA_W-1:0]            mem_rd;
    logic [LA_W-1:0]            mem_wdata;
    logic                       mem_we;

    logic                       s_ready;
    logic                       in_fire;
    logic                       out_fire;
    logic [DIM_WIDTH-1:0]       hmask;
    logic [DIM_WIDTH-1:0]       vmask;
    logic                       grp_end;
    logic                       row_first;
    logic                       row_last;
    logic                       x_last;
    logic                       y_last;
    logic [2:0]                 sh;
    logic [CHANNELS*HS_W-1:0]   hs_new;
    logic [PW-1:0]              avg_pix;
    logic [ACC_W-1:0]           total;
    logic                       unused_tuser;

    // The frame's own counters define geometry; input SOF is not needed.
    assign unused_tuser = s_axis.tuser;

    assign mem_addr = AW'(in_x_q >> hl_q);
    assign mem_rd   = line_mem[mem_addr];

    // Datapath: horizontal sum, vertical accumulation and rounded average.
    always_comb begin
        s_ready   = (state_q == RUN) && !in_done_q && (!m_valid_q || m_axis.tready);
        in_fire   = s_ready && s_axis.tvalid;
        out_fire  = m_valid_q && m_axis.tready;
        hmask     = (DIM_WIDTH'(1) << hl_q) - DIM_WIDTH'(1);
        vmask     = (DIM_WIDTH'(1) << vl_q) - DIM_WIDTH'(1);
        grp_end   = (in_x_q & hmask) == hmask;
        row_first = (in_y_q & vmask) == '0;
        row_last  = (in_y_q & vmask) == vmask;
        x_last    = in_x_q == cfg_w_q - DIM_WIDTH'(1);
        y_last    = in_y_q == cfg_h_q - DIM_WIDTH'(1);
        sh        = {1'b0, hl_q} + {1'b0, vl_q};
        hs_new    = '0;
        avg_pix   = '0;
        mem_wdata = '0;
        total     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hs_new[c*HS_W +: HS_W] = hsum_q[c*HS_W +: HS_W] +
                                     HS_W'(s_axis.tdata[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
            total = (row_first ? '0 : mem_rd[c*ACC_W +: ACC_W]) + ACC_W'(hs_new[c*HS_W +: HS_W]);
            mem_wdata[c*ACC_W +: ACC_W] = total;
            avg_pix[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = round_half_up(total, sh);
        end
    end

    // Control FSM: config acceptance, counters, output register and frame end.
    always_comb begin
        state_d     = state_q;
        cfg_w_d     = cfg_w_q;
        cfg_h_d     = cfg_h_q;
        hl_d        = hl_q;
        vl_d        = vl_q;
        in_x_d      = in_x_q;
        in_y_d      = in_y_q;
        in_done_d   = in_done_q;
        hsum_d      = hsum_q;
        first_out_d = first_out_q;
        final_out_d = final_out_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_user_d    = m_user_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;
        tlast_err_d = tlast_err_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad(src_width, src_height, hratio_log2, vratio_log2)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_w_d     = src_width;
                        cfg_h_d     = src_height;
                        hl_d        = hratio_log2;
                        vl_d        = vratio_log2;
                        in_x_d      = '0;
                        in_y_d      = '0;
                        in_done_d   = 1'b0;
                        hsum_d      = '0;
                        first_out_d = 1'b1;
                        final_out_d = 1'b0;
                        cfg_err_d   = 1'b0;
                        tlast_err_d = 1'b0;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (out_fire) begin
                    m_valid_d = 1'b0;
                end
                if (in_fire) begin
                    if (s_axis.tlast != x_last) begin
                        tlast_err_d = 1'b1;
                    end
                    hsum_d = grp_end ? '0 : hs_new;
                    if (grp_end) begin
                        if (row_last) begin
                            m_data_d    = avg_pix;
                            m_valid_d   = 1'b1;
                            m_last_d    = x_last;
                            m_user_d    = first_out_q;
                            first_out_d = 1'b0;
                            final_out_d = x_last && y_last;
                        end else begin
                            mem_we = 1'b1;
                        end
                    end
                    if (x_last) begin
                        in_x_d = '0;
                        if (y_last) begin
                            in_done_d = 1'b1;
                        end else begin
                            in_y_d = in_y_q + DIM_WIDTH'(1);
                        end
                    end else begin
                        in_x_d = in_x_q + DIM_WIDTH'(1);
                    end
                end
                if (out_fire && final_out_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d     = IDLE;
            m_valid_d   = 1'b0;
            done_d      = 1'b0;
            mem_we      = 1'b0;
            in_done_d   = 1'b0;
            final_out_d = 1'b0;
            hsum_d      = '0;
            cfg_err_d   = cfg_err_q;
        end
    end

    // State and control/data registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            hl_q        <= '0;
            vl_q        <= '0;
            in_x_q      <= '0;
            in_y_q      <= '0;
            in_done_q   <= 1'b0;
            hsum_q      <= '0;
            first_out_q <= 1'b0;
            final_out_q <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_w_q     <= cfg_w_d;
            cfg_h_q     <= cfg_h_d;
            hl_q        <= hl_d;
            vl_q        <= vl_d;
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            in_done_q   <= in_done_d;
            hsum_q      <= hsum_d;
            first_out_q <= first_out_d;
            final_out_q <= final_out_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_user_q    <= m_user_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            tlast_err_q <= tlast_err_d;
        end
    end

    // Line accumulator: partial vertical sums, one entry per output column.
    always_ff @(posedge axi_aclk) begin
        if (mem_we) begin
            line_mem[mem_addr] <= mem_wdata;
        end
    end

    assign busy          = (state_q == RUN);
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign tlast_err     = tlast_err_q;
    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tuser  = m_user_q;
endmodule

// File: tb/tb_video_box_downscaler.sv
// Self-checking bench for video_box_downscaler: randomized frames compared
// against a block-average reference model.
module tb_video_box_downscaler;
    localparam int PW = 24;

    logic        axi_aclk;
    logic        axi_aresetn;
    logic        start;
    logic        abort;
    logic [15:0] src_width;
    logic [15:0] src_height;
    logic [1:0]  hratio_log2;
    logic [1:0]  vratio_log2;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        tlast_err;

    video_box_downscaler_if #(.PW(PW)) s_if ();
    video_box_downscaler_if #(.PW(PW)) m_if ();

    video_box_downscaler dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .start       (start),
        .abort       (abort),
        .src_width   (src_width),
        .src_height  (src_height),
        .hratio_log2 (hratio_log2),
        .vratio_log2 (vratio_log2),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .tlast_err   (tlast_err),
        .s_axis      (s_if),
        .m_axis      (m_if)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int          n_checks;
    int          n_pass;
    logic [23:0] img [0:255];
    logic [25:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic drive_in(input int idx, input int w, input int bad_x);
        int x;
        int y;
        x = idx % w;
        y = idx / w;
        s_if.tdata = img[idx];
        s_if.tlast = (bad_x >= 0 && y == 0) ? (x == bad_x) : (x == w - 1);
        s_if.tuser = (idx == 0);
    endtask

    // Builds the expected output beats: each output channel is the rounded
    // mean of an hf x vf block of source pixels.
    task automatic build_model(input int w, input int hgt, input int hl, input int vl);
        int hf;
        int vf;
        int sum;
        int sh;
        logic [23:0] px;
        logic [23:0] d;
        hf = 1 << hl;
        vf = 1 << vl;
        sh = hl + vl;
        exp_q.delete();
        for (int oy = 0; oy < hgt / vf; oy++) begin
            for (int ox = 0; ox < w / hf; ox++) begin
                d = '0;
                for (int c = 0; c < 3; c++) begin
                    sum = 0;
                    for (int dy = 0; dy < vf; dy++) begin
                        for (int dx = 0; dx < hf; dx++) begin
                            px = img[(oy * vf + dy) * w + ox * hf + dx];
                            sum += int'(px[c*8 +: 8]);
                        end
                    end
                    if (sh > 0) sum = (sum + (1 << (sh - 1))) >> sh;
                    d[c*8 +: 8] = 8'(sum);
                end
                exp_q.push_back({(oy == 0 && ox == 0), (ox == w / hf - 1), d});
            end
        end
    endtask

    task automatic pulse_start(input int w, input int hgt, input int hl, input int vl);
        @(posedge axi_aclk); #1;
        src_width   = 16'(w);
        src_height  = 16'(hgt);
        hratio_log2 = 2'(hl);
        vratio_log2 = 2'(vl);
        start       = 1'b1;
        @(posedge axi_aclk); #1;
        start       = 1'b0;
    endtask

    // mode 0: ramp x+16y (+3 per channel), 1: 1,2,2,2 by column, 2: random.
    task automatic run_frame(input int w, input int hgt, input int hl, input int vl,
                             input int mode, input int rdy_pct, input int vld_pct,
                             input int bad_x, input int abort_at,
                             output logic [25:0] first_out, output int n_done);
        int   total;
        int   in_idx;
        int   cyc;
        int   tail;
        int   n_out;
        int   exp_n;
        bit   in_acc;
        bit   out_acc;
        bit   prev_in_acc;
        bit   lat_chk;
        logic [25:0] e;
        logic [7:0]  v;
        total = w * hgt;
        for (int i = 0; i < total; i++) begin
            for (int c = 0; c < 3; c++) begin
                case (mode)
                    0:       v = 8'((i % w) + 16 * (i / w) + 3 * c);
                    1:       v = ((i % w) % 4 == 0) ? 8'd1 : 8'd2;
                    default: v = 8'($urandom);
                endcase
                img[i][c*8 +: 8] = v;
            end
        end
        build_model(w, hgt, hl, vl);
        exp_n   = exp_q.size();
        lat_chk = (hl == 0 && vl == 0 && rdy_pct == 100);
        n_out = 0; n_done = 0; tail = 0; cyc = 0; in_idx = 0; prev_in_acc = 0;
        first_out = '0;
        pulse_start(w, hgt, hl, vl);
        s_if.tvalid = 1'b1;
        drive_in(0, w, bad_x);
        m_if.tready = ($urandom_range(99) < rdy_pct);
        @(negedge axi_aclk);
        check("busy_run", busy, 1);
        check("cfg_err_clr", cfg_err, 0);
        while (cyc < 4000) begin
            cyc++;
            in_acc  = s_if.tvalid && s_if.tready;
            out_acc = m_if.tvalid && m_if.tready;
            if (done) n_done++;
            if (lat_chk) check("latency", m_if.tvalid, prev_in_acc);
            if (m_if.tvalid && !m_if.tready) check("stall_no_input", s_if.tready, 0);
            if (out_acc) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("extra_out", n_out, exp_n);
                end else begin
                    e = exp_q.pop_front();
                    if (n_out == 1) first_out = {m_if.tuser, m_if.tlast, m_if.tdata};
                    check("out_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, e);
                end
            end
            prev_in_acc = in_acc;
            if (tail > 3) break;
            @(posedge axi_aclk); #1;
            if (in_acc) in_idx++;
            if (abort_at >= 0 && in_idx >= abort_at) begin
                abort       = 1'b1;
                s_if.tvalid = 1'b0;
                @(posedge axi_aclk); #1;
                abort = 1'b0;
                @(negedge axi_aclk);
                check("abort_busy", busy, 0);
                check("abort_tvalid", m_if.tvalid, 0);
                check("abort_tready", s_if.tready, 0);
                for (int k = 0; k < 4; k++) begin
                    if (done) n_done++;
                    @(negedge axi_aclk);
                end
                break;
            end
            if (in_idx < total) begin
                if (!s_if.tvalid || in_acc) s_if.tvalid = ($urandom_range(99) < vld_pct);
                drive_in(in_idx, w, bad_x);
            end else begin
                s_if.tvalid = 1'b0;
            end
            m_if.tready = ($urandom_range(99) < rdy_pct);
            if (in_idx == total && exp_q.size() == 0) tail++;
            @(negedge axi_aclk);
        end
        if (abort_at < 0) begin
            check("outs_left", exp_q.size(), 0);
            check("out_count", n_out, exp_n);
            check("idle_after", busy, 0);
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] fo;
        int          nd;
        int          bad_cfg [7][4];
        n_checks = 0;
        n_pass   = 0;
        axi_aresetn = 1'b0;
        start = 1'b0; abort = 1'b0;
        src_width = '0; src_height = '0; hratio_log2 = '0; vratio_log2 = '0;
        s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_tlast_err", tlast_err, 0);
        check("rst_s_tready", s_if.tready, 0);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_m_tuser", m_if.tuser, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        #2 axi_aresetn = 1'b1;

        // 2x2 box average on a ramp
        run_frame(8, 4, 1, 1, 0, 100, 100, -1, -1, fo, nd);
        check("ramp_px0_ch0", fo[7:0], 9);
        check("ramp_px0_tuser", fo[25], 1);
        check("ramp_done", nd, 1);
        check("ramp_tlast_err", tlast_err, 0);

        // passthrough with one-cycle latency
        run_frame(4, 2, 0, 0, 2, 100, 100, -1, -1, fo, nd);
        check("pass_done", nd, 1);

        // 4x4 box: 28/16 rounds up to 2 on every channel
        run_frame(4, 4, 2, 2, 1, 100, 100, -1, -1, fo, nd);
        check("box_px", fo, {1'b1, 1'b1, 24'h020202});
        check("box_done", nd, 1);

        // rejected configurations
        bad_cfg = '{'{6, 4, 2, 0}, '{0, 4, 0, 0}, '{8, 0, 0, 0}, '{4000, 4, 0, 0},
                    '{8, 4, 3, 0}, '{8, 4, 0, 3}, '{8, 6, 0, 2}};
        for (int i = 0; i < 7; i++) begin
            pulse_start(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2], bad_cfg[i][3]);
            @(negedge axi_aclk);
            check("cfg_err_set", cfg_err, 1);
            check("cfg_rej_busy", busy, 0);
        end

        // random data, random backpressure and input gaps
        run_frame(16, 8, 1, 2, 2, 30, 80, -1, -1, fo, nd);
        check("rand_done", nd, 1);
        run_frame(8, 8, 2, 1, 2, 50, 70, -1, -1, fo, nd);
        check("rand2_done", nd, 1);

        // misplaced input tlast: sticky flag, data unaffected
        run_frame(8, 4, 1, 0, 2, 100, 100, 5, -1, fo, nd);
        check("tlast_err_set", tlast_err, 1);
        check("tlast_frame_done", nd, 1);
        repeat (3) @(negedge axi_aclk);
        check("tlast_err_sticky", tlast_err, 1);

        // abort mid-frame
        run_frame(8, 4, 1, 1, 0, 100, 100, -1, 12, fo, nd);
        check("abort_no_done", nd, 0);

        // recovery after abort
        run_frame(4, 2, 0, 1, 2, 60, 90, -1, -1, fo, nd);
        check("recover_done", nd, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
